// File: rtl/apb_slave_regfile.sv
// APB completer in front of a DEPTH x 8-bit register file.
// Inserts WAIT_CYCLES wait states and flags out-of-range addresses with pslverr.
module apb_slave_regfile #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       pselx,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0]  DEPTH_W = 9'(DEPTH);
    localparam logic [3:0]  WAIT_W  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  prdata_q, prdata_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];

    logic          in_range_s;
    logic [AW-1:0] idx_s;
    logic          load_s;

    // Full 8-bit address is compared against DEPTH, so there is no aliasing.
    always_comb begin
        in_range_s = ({1'b0, paddr} < DEPTH_W);
        idx_s      = paddr[AW-1:0];
    end

    // Next-state, response loading and register-file write decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        mem_d     = mem_q;
        load_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pready_d = 1'b0;
                if (pselx && !penable) begin
                    if (WAIT_CYCLES == 0) begin
                        load_s  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = WAIT_W;
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!pselx) begin
                    // Master abandoned the transfer: nothing is committed.
                    state_d  = ST_IDLE;
                    cnt_d    = 4'd0;
                    pready_d = 1'b0;
                end else if (cnt_q == 4'd1) begin
                    load_s  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (pselx && penable) begin
                    if (pwrite && in_range_s) begin
                        mem_d[idx_s] = pwdata;
                    end else begin
                        mem_d = mem_q;
                    end
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (!pselx) begin
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = 4'd0;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
            end
        endcase

        // prdata only changes on reads; a write leaves the last read value visible.
        if (load_s) begin
            pready_d  = 1'b1;
            pslverr_d = !in_range_s;
            if (!pwrite) begin
                prdata_d = in_range_s ? mem_q[idx_s] : 8'h00;
            end else begin
                prdata_d = prdata_q;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // State, counter, bus response and register-file flops.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            prdata_q  <= 8'h00;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances (0 and 3 wait states, DEPTH=16)
// checked every cycle against a transfer-level model plus literal expectations.
module tb_apb_slave_regfile;

    logic       pclk = 1'b0;
    logic       presetn = 1'b1;
    logic [1:0] sel = 2'b00;
    logic [1:0] en  = 2'b00;
    logic [1:0] wr  = 2'b00;
    logic [1:0][7:0] addr  = '0;
    logic [1:0][7:0] wdata = '0;

    logic [7:0] rdata0, rdata1;
    logic       rdy0, rdy1, err0, err1;

    int checks   = 0;
    int failures = 0;

    // Model state: register contents and expected bus outputs per instance.
    logic [7:0] mem_m  [2][256];
    logic       exp_rdy [2];
    logic       exp_err [2];
    logic [7:0] exp_rd  [2];

    always #5 pclk = ~pclk;

    apb_slave_regfile #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
        .pclk(pclk), .presetn(presetn), .pselx(sel[0]), .penable(en[0]),
        .pwrite(wr[0]), .paddr(addr[0]), .pwdata(wdata[0]),
        .prdata(rdata0), .pready(rdy0), .pslverr(err0)
    );

    apb_slave_regfile #(.DEPTH(16), .WAIT_CYCLES(3)) u_dut1 (
        .pclk(pclk), .presetn(presetn), .pselx(sel[1]), .penable(en[1]),
        .pwrite(wr[1]), .paddr(addr[1]), .pwdata(wdata[1]),
        .prdata(rdata1), .pready(rdy1), .pslverr(err1)
    );

    function automatic int wc(int d);
        return (d == 1) ? 3 : 0;
    endfunction

    function automatic logic [7:0] rd(int d);
        return (d == 1) ? rdata1 : rdata0;
    endfunction

    task automatic chk(string name, int d, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%02h expected=%02h t=%0t", name, d, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_rdy[d] = 1'b0;
            exp_err[d] = 1'b0;
            exp_rd[d]  = 8'h00;
            for (int a = 0; a < 256; a++) mem_m[d][a] = 8'h00;
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge pclk) begin
        chk("pready",  0, {7'd0, rdy0}, {7'd0, exp_rdy[0]});
        chk("pslverr", 0, {7'd0, err0}, {7'd0, exp_err[0]});
        chk("prdata",  0, rdata0, exp_rd[0]);
        chk("pready",  1, {7'd0, rdy1}, {7'd0, exp_rdy[1]});
        chk("pslverr", 1, {7'd0, err1}, {7'd0, exp_err[1]});
        chk("prdata",  1, rdata1, exp_rd[1]);
    end

    // One APB transfer; called 1 time unit after a rising edge, returns likewise.
    // abort_at>0 drops pselx in that access cycle (only meaningful for k <= waits).
    task automatic xfer(int d, bit write, logic [7:0] a, logic [7:0] wd, int abort_at);
        sel[d] = 1'b1; en[d] = 1'b0; wr[d] = write; addr[d] = a; wdata[d] = wd;
        @(posedge pclk); #1;
        en[d] = 1'b1;
        for (int k = 1; k <= wc(d) + 1; k++) begin
            if (k == wc(d) + 1) begin
                exp_rdy[d] = 1'b1;
                exp_err[d] = (a >= 8'd16);
                if (!write) exp_rd[d] = (a < 8'd16) ? mem_m[d][a] : 8'h00;
            end
            if (abort_at == k) begin
                sel[d] = 1'b0; en[d] = 1'b0;
                @(posedge pclk); #1;
                return;
            end
            @(posedge pclk); #1;
        end
        if (write && a < 8'd16) mem_m[d][a] = wd;
        exp_rdy[d] = 1'b0;
        exp_err[d] = 1'b0;
        sel[d] = 1'b0; en[d] = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 presetn = 1'b0;
        #2;
        chk("rst_pready", 0, {7'd0, rdy0}, 8'h00);
        chk("rst_prdata", 1, rdata1, 8'h00);
        @(posedge pclk); @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;

        // Fresh read, zero wait states.
        xfer(0, 1'b0, 8'h03, 8'h00, 0);
        chk("lit_rd03", 0, rd(0), 8'h00);

        // Back-to-back write then read.
        xfer(0, 1'b1, 8'h05, 8'hA5, 0);
        xfer(0, 1'b0, 8'h05, 8'h00, 0);
        chk("lit_rd05", 0, rd(0), 8'hA5);

        // Three wait states, highest legal address.
        xfer(1, 1'b1, 8'h0F, 8'h3C, 0);
        xfer(1, 1'b0, 8'h0F, 8'h00, 0);
        chk("lit_rd0f", 1, rd(1), 8'h3C);

        // Out-of-range accesses and the DEPTH boundary.
        xfer(0, 1'b1, 8'h20, 8'h77, 0);
        xfer(0, 1'b0, 8'h20, 8'h00, 0);
        chk("lit_rd20", 0, rd(0), 8'h00);
        xfer(0, 1'b0, 8'h00, 8'h00, 0);
        chk("lit_rd00", 0, rd(0), 8'h00);
        xfer(0, 1'b1, 8'h0F, 8'h6B, 0);
        xfer(0, 1'b1, 8'h10, 8'hEE, 0);
        xfer(0, 1'b0, 8'h0F, 8'h00, 0);
        chk("lit_rd0f", 0, rd(0), 8'h6B);
        xfer(0, 1'b0, 8'h10, 8'h00, 0);
        chk("lit_rd10", 0, rd(0), 8'h00);

        // Reset asserted in the middle of a waited write.
        xfer(1, 1'b1, 8'h02, 8'h5A, 0);
        sel[1] = 1'b1; en[1] = 1'b0; wr[1] = 1'b1; addr[1] = 8'h02; wdata[1] = 8'h11;
        @(posedge pclk); #1;
        en[1] = 1'b1;
        @(posedge pclk); @(posedge pclk); #1;
        presetn = 1'b0;
        model_reset();
        #1;
        chk("rstmid_pready", 1, {7'd0, rdy1}, 8'h00);
        chk("rstmid_prdata", 1, rdata1, 8'h00);
        sel = 2'b00; en = 2'b00;
        @(posedge pclk); @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        xfer(1, 1'b0, 8'h02, 8'h00, 0);
        chk("lit_rd02", 1, rd(1), 8'h00);

        // Master drops pselx during wait states.
        xfer(1, 1'b1, 8'h04, 8'h42, 0);
        xfer(1, 1'b1, 8'h04, 8'h99, 2);
        @(posedge pclk); #1;
        xfer(1, 1'b0, 8'h04, 8'h00, 0);
        chk("lit_rd04", 1, rd(1), 8'h42);

        // penable without a setup phase is ignored.
        xfer(0, 1'b1, 8'h0A, 8'hC3, 0);
        sel[0] = 1'b1; en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h0A; wdata[0] = 8'h01;
        repeat (3) @(posedge pclk);
        #1;
        chk("lit_noset_rdy", 0, {7'd0, rdy0}, 8'h00);
        sel[0] = 1'b0; en[0] = 1'b0;
        @(posedge pclk); #1;
        xfer(0, 1'b0, 8'h0A, 8'h00, 0);
        chk("lit_rd0a", 0, rd(0), 8'hC3);

        @(posedge pclk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB completer (responder) that sits on the far side of the team's 8-bit APB master.
- Decodes `pselx`/`penable`/`pwrite`, serves reads and writes against an internal 8-bit register file, and inserts a programmable number of wait states.
- Flags out-of-range addresses with `pslverr`.
- All bus outputs are registered, so a master sees clean `pready`/`prdata`.

Parameters:
- `DEPTH`, 16, number of 8-bit registers; legal addresses are 0..DEPTH-1; range 1..256.
- `WAIT_CYCLES`, 0, number of access-phase cycles with `pready`=0 before completion; range 0..15.

Ports:
- `pclk`  input  1  APB clock; all state updates on rising edge.
- `presetn`  input  1  asynchronous active-low reset.
- `pselx`  input  1  slave select.
- `penable`  input  1  access-phase indicator.
- `pwrite`  input  1  1=write, 0=read.
- `paddr`  input  8  register address.
- `pwdata`  input  8  write data.
- `prdata`  output  8  read data, registered.
- `pready`  output  1  transfer-complete, registered.
- `pslverr`  output  1  error response, registered; meaningful only while `pready`=1.

Behaviour:
- **Reset:** `presetn` low clears everything asynchronously, including mid-transfer.
  - `prdata`=0, `pready`=0, `pslverr`=0, FSM=IDLE, wait counter=0.
  - All `DEPTH` registers are cleared to 0.
  - A transfer interrupted by reset never commits its write.
- **FSM states:** IDLE, WAIT, DONE.
- **IDLE**
  - Setup phase is detected as `pselx`=1 and `penable`=0.
  - If `WAIT_CYCLES`=0: go to DONE, and at that edge load `pready`<=1, `pslverr`<=(`paddr`>=`DEPTH`), and `prdata`<=`mem[paddr]` for an in-range read, else 0.
  - Otherwise: load counter<=`WAIT_CYCLES` and go to WAIT with `pready`=0.
- **WAIT** (`pselx`=1, `penable`=1)
  - Decrement the counter each edge.
  - At the edge where the counter is 1: load `pready`/`pslverr`/`prdata` exactly as above and go to DONE.
  - If `pselx` drops while in WAIT (protocol abort): return to IDLE, no write, outputs unchanged except `pready`=0.
- **DONE** (`pready`=1 on the bus)
  - The completion edge is `pselx`&`penable`&`pready`.
  - At that edge, for an in-range write: `mem[paddr]`<=`pwdata`.
  - Out-of-range writes are discarded.
  - `pready`<=0 and `pslverr`<=0 at the same edge.
  - Next state is IDLE. A back-to-back setup in the following cycle is detected from IDLE normally.
- **Latency:** `pready` is high in access cycle number `WAIT_CYCLES`+1, i.e. exactly `WAIT_CYCLES` wait states.
  - Each transfer takes `WAIT_CYCLES`+2 cycles from setup to completion.
- **Read data:**
  - Address and data are sampled from `paddr` at the setup edge (`WAIT_CYCLES`=0) or at the final WAIT edge. The master holds them stable across the transfer.
  - `prdata` holds its last value after completion until the next read loads it.
  - An out-of-range read loads 0.
- **Width/decoding:** the full 8-bit `paddr` is decoded against `DEPTH`, with no aliasing or wrap. With `DEPTH`=256, `pslverr` never asserts.
- **Simultaneous events:** `penable` high without a preceding setup (IDLE with `pselx`&`penable`) is ignored. The slave waits for a proper setup phase, and `pready` stays 0.
- **Read-after-write:** a read of an address written in the immediately preceding transfer returns the new value.

Test Plan:
- Reset then read addr 0x03 with `WAIT_CYCLES`=0 -> `pready`=1 in the first access cycle, `prdata`=0x00, `pslverr`=0.
- Write 0xA5 to 0x05, then read 0x05, back-to-back (`WAIT_CYCLES`=0) -> each transfer takes 2 cycles; the read returns 0xA5; `pslverr`=0 on both.
- `WAIT_CYCLES`=3: write 0x3C to 0x0F, then read it -> `pready` low for 3 access cycles and high on the 4th; read returns 0x3C.
- `DEPTH`=16: write 0x77 to 0x20, then read 0x20 -> both complete with `pslverr`=1; read `prdata`=0x00; a read of 0x00 afterwards is unchanged (0x00).
- `presetn` pulsed low during the WAIT of a write of 0x11 to 0x02 (`WAIT_CYCLES`=3) -> outputs clear immediately; a subsequent read of 0x02 returns 0x00.
- `pselx` dropped during WAIT of a write of 0x99 to 0x04 -> FSM returns to IDLE, `pready` never asserts, and a later read of 0x04 returns the prior value.
